zresult_writeback: RTL

ZRESULT_WRITEBACK -- requirements
Module: zresult_writeback

---
 rtl/zresult_writeback.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/zresult_writeback.sv
// ALU result writeback stage.
// Accepts one 64-bit ALU result at a time. MUL/DIV results commit to the HI/LO
// register pair; any other result has its low word driven onto the datapath bus
// under a valid/ready handshake. From idle, a move-from request drives HI or LO
// onto the same bus. Every completed writeback gives one wb_done pulse and
// advances a wrapping counter.
module zresult_writeback #(
    parameter logic [4:0]  MUL_OP = 5'b10000,
    parameter logic [4:0]  DIV_OP = 5'b01111,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clock,
    input  logic             clear,

    // ALU result input
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [63:0]      z_in,

    // Move-from-HI/LO request
    input  logic             mf_req,
    input  logic             mf_sel,

    // Datapath bus
    output logic [31:0]      bus_out,
    output logic             bus_valid,
    input  logic             bus_ready,

    // Architectural state and status
    output logic [31:0]      hi_out,
    output logic [31:0]      lo_out,
    output logic             wb_done,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        StIdle,
        StDriveZ,
        StWrHilo,
        StDriveMf
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      z_q, z_d;
    logic [4:0]       op_q, op_d;
    logic             sel_q, sel_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             is_hilo_op;
    logic             latched_hilo_op;

    assign is_hilo_op      = (opcode == MUL_OP) || (opcode == DIV_OP);
    assign latched_hilo_op = (op_q == MUL_OP) || (op_q == DIV_OP);

    // State and datapath registers; clear abandons any in-flight result.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            z_q     <= 64'd0;
            op_q    <= 5'd0;
            sel_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: acceptance, HI/LO commit, bus handshake completion.
    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        op_d    = op_q;
        sel_d   = sel_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                // An ALU result takes priority; mf_req is left for the requester
                // to hold until it is served.
                if (in_valid) begin
                    z_d     = z_in;
                    op_d    = opcode;
                    state_d = is_hilo_op ? StWrHilo : StDriveZ;
                end else if (mf_req) begin
                    sel_d   = mf_sel;
                    state_d = StDriveMf;
                end
            end

            StWrHilo: begin
                // Only MUL/DIV results reach here; the opcode check keeps HI/LO
                // safe should the state ever be entered spuriously.
                if (latched_hilo_op) begin
                    hi_d = z_q[63:32];
                    lo_d = z_q[31:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end

            StDriveZ, StDriveMf: begin
                if (bus_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (done_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Bus outputs: driven only in the two bus states, zero elsewhere.
    always_comb begin
        bus_valid = 1'b0;
        bus_out   = 32'd0;
        unique case (state_q)
            StDriveZ: begin
                bus_valid = 1'b1;
                bus_out   = z_q[31:0];
            end
            StDriveMf: begin
                bus_valid = 1'b1;
                bus_out   = sel_q ? hi_q : lo_q;
            end
            default: begin
                bus_valid = 1'b0;
                bus_out   = 32'd0;
            end
        endcase
    end

    assign in_ready = (state_q == StIdle);
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign wb_done  = done_q;
    assign wb_count = cnt_q;

    // A stalled bus word must not change until it is taken.
    a_bus_stable: assert property (
        @(posedge clock) disable iff (clear)
        (bus_valid && !bus_ready) |=> (bus_valid && $stable(bus_out))
    );

    // Every round trip takes at least two cycles, so wb_done never repeats
    // back to back.
    a_done_pulse: assert property (
        @(posedge clock) disable iff (clear)
        wb_done |=> !wb_done
    );

endmodule
